// File: rtl/disp_cmd_pkg.sv
// Shared opcode values, FSM state encoding and opcode helpers for the display-command
// fetch sequencer.
package disp_cmd_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_SET_FG = 8'h01;
    localparam logic [7:0] OP_SET_BG = 8'h02;
    localparam logic [7:0] OP_MOVE   = 8'h03;
    localparam logic [7:0] OP_PUTC   = 8'h04;
    localparam logic [7:0] OP_CLEAR  = 8'h05;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_STROBE  = 3'd1,
        ST_RECOVER = 3'd2,
        ST_DECODE  = 3'd3,
        ST_ISSUE   = 3'd4
    } state_t;

    function automatic logic [3:0] arg_count(input logic [7:0] opcode);
        case (opcode)
            OP_SET_FG, OP_SET_BG, OP_MOVE: arg_count = 4'd2;
            OP_PUTC:                       arg_count = 4'd1;
            default:                       arg_count = 4'd0;
        endcase
    endfunction

    function automatic logic is_valid_op(input logic [7:0] opcode);
        is_valid_op = (opcode <= OP_CLEAR);
    endfunction

endpackage

// File: rtl/disp_cmd_if.sv
// Command handshake between the fetch sequencer (master) and the VGA datapath (slave).
interface disp_cmd_if;
    logic       op_valid;
    logic [2:0] op_code;
    logic [7:0] op_arg0;
    logic [7:0] op_arg1;
    logic       op_ready;

    modport master (output op_valid, op_code, op_arg0, op_arg1, input op_ready);
    modport slave  (input op_valid, op_code, op_arg0, op_arg1, output op_ready);
endinterface

// File: rtl/disp_cmd_sync.sv
// Multi-flop synchronizer for the asynchronous FIFO empty flag; resets to 0 (empty).
module disp_cmd_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/disp_cmd_ctrl.sv
// Display-command FIFO fetch sequencer: strobes bytes out of the FIFO, assembles commands,
// issues them over a valid/ready handshake. Optional argument timeout: DISP_CMD_TIMEOUT_EN.
module disp_cmd_ctrl
    import disp_cmd_pkg::*;
#(
    parameter int RD_PULSE_CYCLES   = 3,
    parameter int RD_RECOVER_CYCLES = 3,
    parameter int TIMEOUT_CYCLES    = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       disp_cmd_in,
    input  logic             nef_in,
    output logic             disp_cmd_rd,
    disp_cmd_if.master       op,
    output logic             bad_cmd,
    output logic             busy
);
    localparam logic [3:0] PULSE_LAST   = 4'(RD_PULSE_CYCLES);
    localparam logic [3:0] RECOVER_LAST = 4'(RD_RECOVER_CYCLES);

    generate
        if (RD_PULSE_CYCLES < 1 || RD_PULSE_CYCLES > 15 ||
            RD_RECOVER_CYCLES < 3 || RD_RECOVER_CYCLES > 15 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
            $error("disp_cmd_ctrl: parameter out of range");
        end
    endgenerate

    logic       nef_s;
    state_t     state_reg;
    logic [3:0] phase_cnt_reg;
    logic [3:0] args_left_reg;
    logic [7:0] byte_reg;
    logic       rd_reg;
    logic       bad_reg;
    logic       op_valid_reg;
    logic [2:0] op_code_reg;
    logic [7:0] arg0_reg;
    logic [7:0] arg1_reg;
`ifdef DISP_CMD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES);
    logic [15:0] timer_reg;
`endif

    disp_cmd_sync #(.STAGES(2)) u_nef_sync (
        .clk (clk),
        .rst (rst),
        .d   (nef_in),
        .q   (nef_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            phase_cnt_reg <= 4'd0;
            args_left_reg <= 4'd0;
            byte_reg      <= 8'h00;
            rd_reg        <= 1'b1;
            bad_reg       <= 1'b0;
            op_valid_reg  <= 1'b0;
            op_code_reg   <= 3'd0;
            arg0_reg      <= 8'h00;
            arg1_reg      <= 8'h00;
`ifdef DISP_CMD_TIMEOUT_EN
            timer_reg     <= 16'd0;
`endif
        end else begin
            bad_reg <= 1'b0;
            case (state_reg)
                ST_FETCH: begin
`ifdef DISP_CMD_TIMEOUT_EN
                    // A stalled partial command is abandoned so the stream can resync.
                    if (args_left_reg != 4'd0 && timer_reg == TIMEOUT_LAST) begin
                        bad_reg       <= 1'b1;
                        args_left_reg <= 4'd0;
                        timer_reg     <= 16'd0;
                    end else if (nef_s) begin
                        state_reg     <= ST_STROBE;
                        rd_reg        <= 1'b0;
                        phase_cnt_reg <= 4'd1;
                        timer_reg     <= 16'd0;
                    end else if (args_left_reg != 4'd0) begin
                        timer_reg     <= timer_reg + 16'd1;
                    end
`else
                    if (nef_s) begin
                        state_reg     <= ST_STROBE;
                        rd_reg        <= 1'b0;
                        phase_cnt_reg <= 4'd1;
                    end
`endif
                end
                ST_STROBE: begin
                    if (phase_cnt_reg == PULSE_LAST) begin
                        byte_reg      <= disp_cmd_in;
                        rd_reg        <= 1'b1;
                        state_reg     <= ST_RECOVER;
                        phase_cnt_reg <= 4'd1;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (phase_cnt_reg == RECOVER_LAST) begin
                        state_reg     <= ST_DECODE;
                        phase_cnt_reg <= 4'd0;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 4'd1;
                    end
                end
                ST_DECODE: begin
                    state_reg <= ST_FETCH;
                    if (args_left_reg == 4'd0) begin
                        if (!is_valid_op(byte_reg)) begin
                            bad_reg <= 1'b1;
                        end else begin
                            op_code_reg   <= byte_reg[2:0];
                            arg0_reg      <= 8'h00;
                            arg1_reg      <= 8'h00;
                            args_left_reg <= arg_count(byte_reg);
                            if (byte_reg != OP_NOP && arg_count(byte_reg) == 4'd0) begin
                                state_reg    <= ST_ISSUE;
                                op_valid_reg <= 1'b1;
                            end
                        end
                    end else begin
                        // Remaining count equal to the full count means this is the first argument.
                        if (args_left_reg == arg_count({5'b00000, op_code_reg}))
                            arg0_reg <= byte_reg;
                        else
                            arg1_reg <= byte_reg;
                        args_left_reg <= args_left_reg - 4'd1;
                        if (args_left_reg == 4'd1) begin
                            state_reg    <= ST_ISSUE;
                            op_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (op.op_ready) begin
                        op_valid_reg <= 1'b0;
                        state_reg    <= ST_FETCH;
                    end
                end
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

    assign disp_cmd_rd = rd_reg;
    assign bad_cmd     = bad_reg;
    assign busy        = (state_reg != ST_FETCH) && (args_left_reg == 4'd0);
    assign op.op_valid = op_valid_reg;
    assign op.op_code  = op_code_reg;
    assign op.op_arg0  = arg0_reg;
    assign op.op_arg1  = arg1_reg;
endmodule
